// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
//
// Definitions shared by the UART receiver and transmitter:
//   rx_state_t      - receiver FSM state encoding
//   PARITY_EVEN/ODD - meaning of the parity select input
//   clks_per_bit()  - system clocks per line bit (integer division)
//   cnt_width()     - width of a counter that must reach clks_per_bit-1
//   parity_mismatch - parity verdict from the XOR of data and parity bits
// ---------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP1  = 3'd4,
        STOP2  = 3'd5
    } rx_state_t;

    localparam logic PARITY_EVEN = 1'b0;
    localparam logic PARITY_ODD  = 1'b1;

    function automatic int clks_per_bit(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

    function automatic int cnt_width(input int cpb);
        return (cpb > 1) ? $clog2(cpb) : 1;
    endfunction

    // ones: XOR over all data bits and the received parity bit.
    // Even parity wants that XOR to be 0, odd parity wants it to be 1.
    function automatic logic parity_mismatch(input logic ones, input logic sel);
        logic bad;
        case (sel)
            PARITY_EVEN: bad = ones;
            PARITY_ODD:  bad = ~ones;
            default:     bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/uart_sync2.sv
// ---------------------------------------------------------------------------
// uart_sync2
//
// Two-flop synchronizer for a single asynchronous input bit.
//   RESET_VAL - value both flops take while rst is high
// Ports:
//   clk - destination clock
//   rst - asynchronous reset, active-high
//   d   - asynchronous input
//   q   - synchronized output (two clocks of latency)
// ---------------------------------------------------------------------------
module uart_sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx
//
// UART receiver: 8 data bits LSB first, optional even/odd parity, one or two
// stop bits. Frame format is latched at start-bit detection, so config input
// changes during a frame do not disturb it.
//
// Parameters:
//   p_clk_speed_hz - system clock frequency in Hz
//   p_baud_rate    - line bit rate; p_clk_speed_hz / p_baud_rate must be >= 4
//
// Ports:
//   clk_i        - system clock
//   rst_i        - asynchronous reset, active-high (aborts any frame)
//   enable_i     - allows start-bit detection (looked at only in IDLE)
//   data_i       - asynchronous serial line, idle high
//   parity_en_i  - 1: a parity bit follows the data bits
//   parity_sel_i - 0: even parity, 1: odd parity
//   stop_sel_i   - 0: one stop bit, 1: two stop bits
//   data_o       - last received byte, held until the next data_valid_o
//   data_valid_o - one-cycle strobe at the end of every frame
//   parity_err_o - parity mismatch, valid with data_valid_o only
//   frame_err_o  - a stop bit was sampled low, valid with data_valid_o only
//   busy_o       - high from start-bit detection until back in IDLE
//
// Build option:
//   UART_RX_MAJORITY_EN - when defined, every bit decision is the 2-of-3
//   majority of the synchronized line over three consecutive clocks centred
//   on the bit midpoint; decisions then land one clock later. When undefined
//   a single sample at the midpoint is used.
// ---------------------------------------------------------------------------
module uart_rx
    import uart_pkg::*;
#(
    parameter int p_clk_speed_hz = 50_000_000,
    parameter int p_baud_rate    = 115_200
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       enable_i,
    input  logic       data_i,
    input  logic       parity_en_i,
    input  logic       parity_sel_i,
    input  logic       stop_sel_i,
    output logic [7:0] data_o,
    output logic       data_valid_o,
    output logic       parity_err_o,
    output logic       frame_err_o,
    output logic       busy_o
);

    localparam int CPB = clks_per_bit(p_clk_speed_hz, p_baud_rate);
    localparam int CW  = cnt_width(CPB);

    // START is entered with the counter at 0 one clock after the synced
    // falling edge, so deciding at CPB/2-1 lands on the start-bit midpoint.
    // The majority vote needs the sample after the midpoint as well.
`ifdef UART_RX_MAJORITY_EN
    localparam int START_DEC = CPB / 2;
`else
    localparam int START_DEC = CPB / 2 - 1;
`endif

    localparam logic [CW-1:0] START_LAST = CW'(START_DEC);
    localparam logic [CW-1:0] BIT_LAST   = CW'(CPB - 1);

    localparam logic [2:0] ST_IDLE   = IDLE;
    localparam logic [2:0] ST_START  = START;
    localparam logic [2:0] ST_DATA   = DATA;
    localparam logic [2:0] ST_PARITY = PARITY;
    localparam logic [2:0] ST_STOP1  = STOP1;
    localparam logic [2:0] ST_STOP2  = STOP2;

    logic          line_s;     // synchronized line
    logic [1:0]    warm;       // fills with ones once line_s carries real data
    logic          line_q;     // previous line_s, forced low until trusted
    logic          fall;       // synced falling edge after a trusted high
    logic          bit_val;    // bit decision at the current sample point

    logic [2:0]    state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift_q;
    logic          ones_q;     // running XOR of the data bits
    logic          par_en_q;
    logic          par_sel_q;
    logic          stop2_q;
    logic          perr_q;
    logic          ferr_q;

    uart_sync2 #(
        .RESET_VAL(1'b1)
    ) u_sync (
        .clk(clk_i),
        .rst(rst_i),
        .d  (data_i),
        .q  (line_s)
    );

    // The synchronizer resets to 1, so for the first two clocks after reset
    // line_s shows the reset value rather than the line. Those clocks must not
    // count as "line seen high", otherwise a stuck-low line would look like a
    // start bit. line_q only becomes 1 from a trusted high sample, so a fall
    // always implies the line was genuinely high beforehand.
    assign fall = line_q & ~line_s;

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] hist;   // hist[0]: line_s one clock ago, hist[1]: two ago

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hist <= 2'b11;
        end else begin
            hist <= {hist[0], line_s};
        end
    end

    assign bit_val = (hist[1] & hist[0]) | (hist[1] & line_s) | (hist[0] & line_s);
`else
    assign bit_val = line_s;
`endif

    assign busy_o = (state != ST_IDLE);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            warm         <= 2'b00;
            line_q       <= 1'b0;
            state        <= ST_IDLE;
            cnt          <= '0;
            bit_idx      <= 3'd0;
            shift_q      <= 8'h00;
            ones_q       <= 1'b0;
            par_en_q     <= 1'b0;
            par_sel_q    <= 1'b0;
            stop2_q      <= 1'b0;
            perr_q       <= 1'b0;
            ferr_q       <= 1'b0;
            data_o       <= 8'h00;
            data_valid_o <= 1'b0;
            parity_err_o <= 1'b0;
            frame_err_o  <= 1'b0;
        end else begin
            warm         <= {warm[0], 1'b1};
            line_q       <= warm[1] & line_s;
            data_valid_o <= 1'b0;
            parity_err_o <= 1'b0;
            frame_err_o  <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (enable_i && fall) begin
                        par_en_q  <= parity_en_i;
                        par_sel_q <= parity_sel_i;
                        stop2_q   <= stop_sel_i;
                        cnt       <= '0;
                        state     <= ST_START;
                    end
                end

                ST_START: begin
                    if (cnt == START_LAST) begin
                        // From here on the counter wraps at each bit midpoint,
                        // so every later decision is CPB clocks after the last.
                        cnt     <= '0;
                        bit_idx <= 3'd0;
                        ones_q  <= 1'b0;
                        perr_q  <= 1'b0;
                        ferr_q  <= 1'b0;
                        state   <= bit_val ? ST_IDLE : ST_DATA;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                ST_DATA, ST_PARITY, ST_STOP1, ST_STOP2: begin
                    if (cnt != BIT_LAST) begin
                        cnt <= cnt + CW'(1);
                    end else begin
                        cnt <= '0;
                        case (state)
                            ST_DATA: begin
                                shift_q <= {bit_val, shift_q[7:1]};
                                ones_q  <= ones_q ^ bit_val;
                                bit_idx <= bit_idx + 3'd1;
                                if (bit_idx == 3'd7) begin
                                    state <= par_en_q ? ST_PARITY : ST_STOP1;
                                end
                            end

                            ST_PARITY: begin
                                perr_q <= parity_mismatch(ones_q ^ bit_val, par_sel_q);
                                state  <= ST_STOP1;
                            end

                            ST_STOP1: begin
                                if (stop2_q) begin
                                    ferr_q <= ~bit_val;
                                    state  <= ST_STOP2;
                                end else begin
                                    data_o       <= shift_q;
                                    data_valid_o <= 1'b1;
                                    parity_err_o <= perr_q;
                                    frame_err_o  <= ~bit_val;
                                    state        <= ST_IDLE;
                                end
                            end

                            default: begin
                                // ST_STOP2: finishing at the midpoint leaves
                                // half a bit to catch a back-to-back start.
                                data_o       <= shift_q;
                                data_valid_o <= 1'b1;
                                parity_err_o <= perr_q;
                                frame_err_o  <= ferr_q | ~bit_val;
                                state        <= ST_IDLE;
                            end
                        endcase
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx
//
// Bench for uart_rx at 10 clocks per bit. The driver serialises frames onto
// data_i and pushes the expected {byte, parity_err, frame_err} word; a monitor
// pops and compares on every data_valid_o pulse.
// ---------------------------------------------------------------------------
module tb_uart_rx;

    localparam int CLK_HZ = 1_000_000;
    localparam int BAUD   = 100_000;
    localparam int CPB    = CLK_HZ / BAUD;
    localparam int W      = 10;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       rst_i;
    logic       enable_i;
    logic       data_i;
    logic       parity_en_i;
    logic       parity_sel_i;
    logic       stop_sel_i;
    logic [7:0] data_o;
    logic       data_valid_o;
    logic       parity_err_o;
    logic       frame_err_o;
    logic       busy_o;

    always #5 clk = ~clk;

    uart_rx #(
        .p_clk_speed_hz(CLK_HZ),
        .p_baud_rate   (BAUD)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .enable_i    (enable_i),
        .data_i      (data_i),
        .parity_en_i (parity_en_i),
        .parity_sel_i(parity_sel_i),
        .stop_sel_i  (stop_sel_i),
        .data_o      (data_o),
        .data_valid_o(data_valid_o),
        .parity_err_o(parity_err_o),
        .frame_err_o (frame_err_o),
        .busy_o      (busy_o)
    );

    // ---------------- scoreboard state ----------------
    logic [W-1:0] exp_q[$];
    int           n_checks = 0;
    int           n_fail   = 0;
    int           n_valid  = 0;
    logic         prev_valid = 1'b0;
    logic         stray_flags = 1'b0;
    logic         sb_ignore = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (!rst_i) begin
            if (data_valid_o) begin
                logic [W-1:0] exp_w;
                n_valid++;
                check_eq("valid_single", {31'd0, prev_valid}, 32'd0);
                if (!sb_ignore) begin
                    check_eq("sb_pending", {31'd0, (exp_q.size() != 0)}, 32'd1);
                    if (exp_q.size() != 0) begin
                        exp_w = exp_q.pop_front();
                        check_eq("frame", {22'd0, data_o, parity_err_o, frame_err_o}, {22'd0, exp_w});
                    end
                end
            end else if (parity_err_o || frame_err_o) begin
                stray_flags = 1'b1;
            end
        end
        prev_valid = data_valid_o;
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic set_cfg(input logic pen, input logic psel, input logic two_stop);
        parity_en_i  = pen;
        parity_sel_i = psel;
        stop_sel_i   = two_stop;
    endtask

    // Serialises one frame. flip_par inverts the parity bit, stop2_low drives
    // the second stop bit low, spike inverts the line for one clock at each
    // bit midpoint.
    task automatic send_frame(input logic [7:0] b, input logic pen, input logic psel,
                              input logic two_stop, input logic flip_par,
                              input logic stop2_low, input logic spike);
        logic [11:0] bits;
        int          n;
        bits = '0;
        n    = 0;
        bits[n] = 1'b0;
        n++;
        for (int i = 0; i < 8; i++) begin
            bits[n] = b[i];
            n++;
        end
        if (pen) begin
            bits[n] = (psel ? ~(^b) : (^b)) ^ flip_par;
            n++;
        end
        bits[n] = 1'b1;
        n++;
        if (two_stop) begin
            bits[n] = ~stop2_low;
            n++;
        end
        for (int k = 0; k < n; k++) begin
            for (int c = 0; c < CPB; c++) begin
                data_i = (spike && c == CPB / 2) ? ~bits[k] : bits[k];
                tick();
            end
        end
        data_i = 1'b1;
    endtask

    task automatic expect_frame(input logic [7:0] b, input logic perr, input logic ferr);
        exp_q.push_back({b, perr, ferr});
    endtask

    task automatic wait_drain(input int budget);
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < budget) begin
            tick();
            t++;
        end
        if (exp_q.size() != 0) begin
            check_eq("drain_timeout", exp_q.size(), 32'd0);
            exp_q.delete();
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] hello [5];
        logic [7:0] bytes_mid;
        int         v0;

        hello[0] = 8'h48;
        hello[1] = 8'h45;
        hello[2] = 8'h4C;
        hello[3] = 8'h4C;
        hello[4] = 8'h4F;

        rst_i    = 1'b1;
        enable_i = 1'b1;
        data_i   = 1'b1;
        set_cfg(1'b0, 1'b0, 1'b0);
        ticks(3);

        // Reset state
        check_eq("rst_data", {24'd0, data_o}, 32'd0);
        check_eq("rst_valid", {31'd0, data_valid_o}, 32'd0);
        check_eq("rst_perr", {31'd0, parity_err_o}, 32'd0);
        check_eq("rst_ferr", {31'd0, frame_err_o}, 32'd0);
        check_eq("rst_busy", {31'd0, busy_o}, 32'd0);
        rst_i = 1'b0;
        ticks(20);

        // 8N1 'H'
        v0 = n_valid;
        expect_frame(8'h48, 1'b0, 1'b0);
        send_frame(8'h48, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        wait_drain(40);
        ticks(10);
        check_eq("8n1_count", n_valid - v0, 32'd1);
        check_eq("8n1_busy_after", {31'd0, busy_o}, 32'd0);
        ticks(30);
        check_eq("data_hold", {24'd0, data_o}, 32'h48);

        // Enable and config changed mid-frame: latched 8N1 format must win
        v0 = n_valid;
        bytes_mid = 8'h3C;
        expect_frame(bytes_mid, 1'b0, 1'b0);
        fork
            send_frame(bytes_mid, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            begin
                ticks(45);
                enable_i = 1'b0;
                set_cfg(1'b1, 1'b1, 1'b1);
            end
        join
        wait_drain(40);
        check_eq("midcfg_count", n_valid - v0, 32'd1);
        enable_i = 1'b1;
        set_cfg(1'b0, 1'b0, 1'b0);
        ticks(20);

        // 8O1 "HELLO" back-to-back
        v0 = n_valid;
        set_cfg(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            expect_frame(hello[i], 1'b0, 1'b0);
            send_frame(hello[i], 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        wait_drain(40);
        ticks(10);
        check_eq("hello_count", n_valid - v0, 32'd5);
        ticks(20);

        // 8E2 with inverted parity bit, then with STOP2 low
        v0 = n_valid;
        set_cfg(1'b1, 1'b0, 1'b1);
        expect_frame(8'h4C, 1'b1, 1'b0);
        send_frame(8'h4C, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        wait_drain(40);
        ticks(20);
        expect_frame(8'h4C, 1'b0, 1'b1);
        send_frame(8'h4C, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        wait_drain(40);
        ticks(20);
        check_eq("8e2_count", n_valid - v0, 32'd2);
        set_cfg(1'b0, 1'b0, 1'b0);

        // Glitch: 3 clocks low is a false start
        v0 = n_valid;
        data_i = 1'b0;
        ticks(3);
        data_i = 1'b1;
        ticks(2);
        check_eq("glitch_busy_seen", {31'd0, busy_o}, 32'd1);
        ticks(7);
        check_eq("glitch_busy_clear", {31'd0, busy_o}, 32'd0);
        ticks(30);
        check_eq("glitch_count", n_valid - v0, 32'd0);

        // Reset during data bit 4 of 0x5A, then a stuck-low line
        v0 = n_valid;
        data_i = 1'b0;
        ticks(CPB);
        for (int i = 0; i < 4; i++) begin
            data_i = (i % 2 == 1);
            ticks(CPB);
        end
        data_i = 1'b1;
        ticks(CPB / 2);
        check_eq("midframe_busy", {31'd0, busy_o}, 32'd1);
        data_i = 1'b0;
        rst_i  = 1'b1;
        #1;
        check_eq("arst_data", {24'd0, data_o}, 32'd0);
        check_eq("arst_valid", {31'd0, data_valid_o}, 32'd0);
        check_eq("arst_errs", {30'd0, parity_err_o, frame_err_o}, 32'd0);
        check_eq("arst_busy", {31'd0, busy_o}, 32'd0);
        ticks(3);
        rst_i = 1'b0;
        ticks(60);
        check_eq("stuck_low_count", n_valid - v0, 32'd0);
        check_eq("stuck_low_busy", {31'd0, busy_o}, 32'd0);
        data_i = 1'b1;
        ticks(20);
        expect_frame(8'h81, 1'b0, 1'b0);
        send_frame(8'h81, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        wait_drain(40);
        ticks(10);
        check_eq("after_rst_count", n_valid - v0, 32'd1);
        ticks(20);

        // 0xA5 with a one-clock inverted spike at every bit midpoint
`ifdef UART_RX_MAJORITY_EN
        expect_frame(8'hA5, 1'b0, 1'b0);
        send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        wait_drain(40);
        ticks(20);
        check_eq("spike_data", {24'd0, data_o}, 32'hA5);
`else
        sb_ignore = 1'b1;
        send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        ticks(4 * CPB);
        check_eq("spike_corrupts", {31'd0, (data_o != 8'hA5)}, 32'd1);
        sb_ignore = 1'b0;
`endif

        check_eq("flags_outside_valid", {31'd0, stray_flags}, 32'd0);
        check_eq("sb_leftover", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
Serial UART receiver, the counterpart of uart_tx. It samples an asynchronous serial line and recovers 8-bit data bytes, LSB first. Parity (none/even/odd) and 1 or 2 stop bits are run-time selectable. It sits between the pad or loopback line and the byte-level consumer, and pulses a valid strobe with error flags once per received frame.

Parameters:
p_clk_speed_hz, 50_000_000, system clock frequency in Hz
p_baud_rate, 115_200, line bit rate; CLKS_PER_BIT = p_clk_speed_hz / p_baud_rate (integer division, must be >= 4)

Ports:
clk_i  input  1  system clock
rst_i  input  1  asynchronous reset, active-high
enable_i  input  1  allows start-bit detection; sampled only in IDLE
data_i  input  1  serial line, asynchronous to clk_i, idle high
parity_en_i  input  1  1 = parity bit expected after data bits
parity_sel_i  input  1  0 = even parity, 1 = odd parity
stop_sel_i  input  1  0 = one stop bit, 1 = two stop bits
data_o  output  8  last received byte; held until the next data_valid_o
data_valid_o  output  1  single-cycle pulse at end of frame
parity_err_o  output  1  qualifies data_valid_o: parity mismatch
frame_err_o  output  1  qualifies data_valid_o: a stop bit sampled low
busy_o  output  1  high from start-bit detection until return to IDLE

Behaviour:
- Reset values: data_o=0, data_valid_o=0, parity_err_o=0, frame_err_o=0, busy_o=0, FSM=IDLE, synchronizer flops=1.
- Reset mid-frame aborts immediately. No partial byte is reported.
- data_i passes through a 2-FF synchronizer (reset value 1). All decisions use the synchronized value.
- After reset, the line must be seen high at least once before a start bit is accepted. This prevents a stuck-low line from producing false frames.
- FSM states: IDLE, START, DATA, PARITY, STOP1, STOP2.
- IDLE: on a synced falling edge while enable_i=1:
  - latch parity_en_i, parity_sel_i, stop_sel_i
  - set busy_o, clear the baud counter, go to START.
- START: wait CLKS_PER_BIT/2 cycles, then resample the line.
  - Low: go to DATA (mid-bit alignment achieved).
  - High: false start; go to IDLE with no output.
- DATA: sample every CLKS_PER_BIT cycles; shift into the MSB of an 8-bit shift register.
  - After 8 samples: go to PARITY if parity is latched enabled, else STOP1.
- PARITY: sample one bit.
  - Mismatch when XOR(data bits, parity bit) != latched parity_sel (even: XOR must be 0; odd: XOR must be 1).
- STOP1: sample one bit; low sets the frame error.
  - Go to STOP2 if two stop bits are latched, else finish.
- STOP2: sample one bit; low sets the frame error; finish.
- Finish, in the cycle after the final stop-bit sample:
  - data_o <= shift register; data_valid_o=1 for exactly 1 cycle
  - parity_err_o and frame_err_o driven for that same cycle (0 otherwise)
  - busy_o=0, state = IDLE.
- The frame is reported even when the error flags are set.
- Finishing at the stop-bit midpoint lets the next start edge be detected back-to-back, with up to half a bit of tolerance.
- enable_i deasserted mid-frame has no effect; the frame completes.
- Config input changes mid-frame are ignored (latched values are used).
- Baud counter: $clog2(CLKS_PER_BIT) bits, wraps to 0 on each sample.
- Latency: data_valid_o rises 1 clk after the final stop-bit midpoint sample, plus 2 clks of synchronizer delay from the line.

Optional Feature:
UART_RX_MAJORITY_EN
- Defined: each bit value (start check, data, parity, stop) is the 2-of-3 majority of the synced line at counter positions mid-1, mid, and mid+1. The decision is made at mid+1, so all sample points shift 1 clk later.
- Undefined: a single sample at mid; no extra flops.

Decomposition:
- Shared package uart_pkg:
  - typedef enum rx_state_t {IDLE, START, DATA, PARITY, STOP1, STOP2}
  - localparam functions for CLKS_PER_BIT and the counter width
  - PARITY_EVEN=0, PARITY_ODD=1 constants (shared with uart_tx).
- One sub-module: uart_sync2, the 2-flop synchronizer with a reset-value parameter.

Test Plan:
Common setup: p_clk_speed_hz=1_000_000, p_baud_rate=100_000 (10 clks/bit).
- 8N1 byte 0x48 ('H') driven at 10 clks/bit -> one data_valid_o pulse, data_o=0x48, parity_err_o=0, frame_err_o=0, busy_o low afterwards.
- 8O1, bytes "HELLO" sent back-to-back with no idle gap -> 5 valid pulses with data 0x48, 0x45, 0x4C, 0x4C, 0x4F; no errors.
- 8E2, byte 0x4C sent with an inverted parity bit -> data_o=0x4C, parity_err_o=1. Same again with STOP2 driven low -> frame_err_o=1.
- Glitch: line low for 3 clks then high -> no valid pulse; busy_o returns to 0 by cycle 6.
- rst_i asserted at data bit 4 -> all outputs 0 immediately. After release with the line held low, no frame until the line goes high and then falls.
- With UART_RX_MAJORITY_EN defined, byte 0xA5 with a 1-clk inverted spike at every bit midpoint -> data_o=0xA5, no errors. Without the macro, data_o != 0xA5.
